serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/wholesub_pkg.sv | 17 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/wholesub.sv | 22 ++
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/wholesub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding and the full-subtractor truth tables.
package wholesub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Truth tables indexed by {a, b, borrow_in}; bit i is the output for index i.
  // Difference is the odd-parity of the three inputs.
  localparam logic [7:0] DIFF_TT   = 8'b1001_0110;
  // Borrow is raised when a < b + borrow_in for the single bit.
  localparam logic [7:0] BORROW_TT = 8'b1000_1110;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The master side supplies operands and consumes results; the slave is the block.
interface serial_subtractor_if #(
  parameter int N = 3
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         busy;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );
endinterface

// File: rtl/wholesub.sv
// One-bit full subtractor: the dual of the full-adder cell.
// Implemented as truth-table lookups so the behaviour is visible in the package.
module wholesub
  import wholesub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic [2:0] idx;

  // Look up difference and borrow for the current input combination
  always_comb begin
    idx        = {a, b, borrow_in};
    diff       = DIFF_TT[idx];
    borrow_out = BORROW_TT[idx];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one shared full-subtractor stage walks the
// operands LSB first over N cycles, then holds the result until accepted.
module serial_subtractor
  import wholesub_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   io
);

  localparam int CW = $clog2(N + 1);

  state_t          state_reg, state_next;
  logic [N-1:0]    a_reg, b_reg;
  logic            borrow_reg;
  logic [N-1:0]    work_reg;
  logic [N-1:0]    diff_reg;
  logic            borrow_out_reg;
  logic [CW-1:0]   cnt_reg;

  logic            stage_diff, stage_borrow;
  logic            last_bit;
  logic [N:0]      shift_wide;
  logic [N-1:0]    shift_next;

  // Single stage reused every cycle on the current low bits
  wholesub u_stage (
    .a          (a_reg[0]),
    .b          (b_reg[0]),
    .borrow_in  (borrow_reg),
    .diff       (stage_diff),
    .borrow_out (stage_borrow)
  );

  // New difference bit enters at the MSB so the LSB ends up at bit 0 after N shifts
  always_comb begin
    last_bit   = (cnt_reg == CW'(N - 1));
    shift_wide = {stage_diff, work_reg};
    shift_next = shift_wide[N:1];
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs decoded from the current state
  always_comb begin
    state_next   = state_reg;
    io.in_ready  = 1'b0;
    io.busy      = 1'b0;
    io.out_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) state_next = BUSY;
      end
      BUSY: begin
        io.busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg          <= '0;
      b_reg          <= '0;
      borrow_reg     <= 1'b0;
      work_reg       <= '0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (io.in_valid) begin
            a_reg      <= io.a;
            b_reg      <= io.b;
            borrow_reg <= io.borrow_in;
            cnt_reg    <= '0;
          end
        end
        BUSY: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          borrow_reg <= stage_borrow;
          work_reg   <= shift_next;
          cnt_reg    <= cnt_reg + CW'(1);
          // Result registers change only on the final bit so the previous
          // answer stays visible until the new one is complete
          if (last_bit) begin
            diff_reg       <= shift_next;
            borrow_out_reg <= stage_borrow;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.diff       = diff_reg;
  assign io.borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=3): directed table, hold,
// reset-abort, randomized and exhaustive operations against an arithmetic model.
module tb_serial_subtractor;
  localparam int N    = 3;
  localparam int MASK = (1 << N) - 1;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  serial_subtractor_if #(.N(N)) sif ();

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int bin;
    int d;
    int bo;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_diff(input int a, input int b, input int bin);
    return (a - b - bin) & MASK;
  endfunction

  function automatic int model_borrow(input int a, input int b, input int bin);
    return (a < b + bin) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: handshake, scramble inputs, measure latency, optional hold
  task automatic run_op(input int a, input int b, input int bin, input int hold,
                        output int d, output int bo);
    int lat;
    int d0;
    chk("in_ready_before_op", int'(sif.in_ready), 1);
    sif.a         = a[N-1:0];
    sif.b         = b[N-1:0];
    sif.borrow_in = bin[0];
    sif.in_valid  = 1'b1;
    sif.out_ready = (hold == 0);
    tick();
    sif.in_valid  = 1'b0;
    sif.a         = N'($urandom);
    sif.b         = N'($urandom);
    sif.borrow_in = 1'($urandom);
    chk("busy_after_handshake", int'(sif.busy), 1);
    lat = 0;
    while (!sif.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency_edges", lat, N);
    d  = int'(sif.diff);
    bo = int'(sif.borrow_out);
    d0 = d;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", int'(sif.out_valid), 1);
      chk("hold_diff", int'(sif.diff), d0);
      chk("hold_in_ready", int'(sif.in_ready), 0);
    end
    sif.out_ready = 1'b1;
    tick();
    chk("accept_out_valid", int'(sif.out_valid), 0);
    $display("op a=%0d b=%0d bin=%0d -> diff=%0d borrow=%0d lat=%0d", a, b, bin, d, bo, lat);
  endtask

  initial begin
    int d, bo, a, b, bin;
    vecs[0] = '{a: 5, b: 3, bin: 0, d: 2, bo: 0};
    vecs[1] = '{a: 3, b: 5, bin: 0, d: 6, bo: 1};
    vecs[2] = '{a: 0, b: 0, bin: 1, d: 7, bo: 1};
    vecs[3] = '{a: 7, b: 7, bin: 0, d: 0, bo: 0};

    sif.in_valid  = 1'b0;
    sif.a         = '0;
    sif.b         = '0;
    sif.borrow_in = 1'b0;
    sif.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("reset_in_ready", int'(sif.in_ready), 1);
    chk("reset_out_valid", int'(sif.out_valid), 0);
    chk("reset_busy", int'(sif.busy), 0);
    chk("reset_diff", int'(sif.diff), 0);
    chk("reset_borrow", int'(sif.borrow_out), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, d, bo);
      chk("vec_diff", d, vecs[i].d);
      chk("vec_borrow", bo, vecs[i].bo);
    end

    // Result held while consumer stalls
    run_op(7, 7, 0, 5, d, bo);
    chk("hold_final_diff", d, 0);
    chk("hold_final_borrow", bo, 0);

    // Result retained in IDLE
    run_op(3, 5, 0, 0, d, bo);
    tick();
    chk("idle_retain_diff", int'(sif.diff), 6);

    // Reset on the 2nd BUSY cycle aborts the operation
    sif.a = 3'd1; sif.b = 3'd6; sif.borrow_in = 1'b1; sif.in_valid = 1'b1;
    tick();
    sif.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(sif.in_ready), 1);
    chk("abort_busy", int'(sif.busy), 0);
    chk("abort_out_valid", int'(sif.out_valid), 0);
    chk("abort_diff", int'(sif.diff), 0);
    chk("abort_borrow", int'(sif.borrow_out), 0);
    tick();
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < N + 3; i++) begin
        tick();
        if (sif.out_valid) seen = 1;
      end
      chk("abort_no_result", seen, 0);
    end
    run_op(6, 2, 1, 0, d, bo);
    chk("post_abort_diff", d, model_diff(6, 2, 1));
    chk("post_abort_borrow", bo, model_borrow(6, 2, 1));

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(MASK));
      b = int'($urandom_range(MASK));
      bin = int'($urandom_range(1));
      run_op(a, b, bin, int'($urandom_range(2)), d, bo);
      chk("rand_diff", d, model_diff(a, b, bin));
      chk("rand_borrow", bo, model_borrow(a, b, bin));
    end

    // Exhaustive back-to-back
    for (int i = 0; i < 128; i++) begin
      a = (i >> 4) & 7;
      b = (i >> 1) & 7;
      bin = i & 1;
      run_op(a, b, bin, 0, d, bo);
      chk("exh_diff", d, model_diff(a, b, bin));
      chk("exh_borrow", bo, model_borrow(a, b, bin));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
